// File: rtl/seg_pkg.sv
// Shared definitions for the hex scroll display path: active-low segment
// codes, display mode encoding, scroll ring length and lookup helpers.
package seg_pkg;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Eight nibbles followed by four blank slots
    localparam int RING_LEN = 12;

    typedef enum logic [1:0] {
        MODE_LO     = 2'b00,
        MODE_HI     = 2'b01,
        MODE_SCROLL = 2'b10,
        MODE_OFF    = 2'b11
    } seg_mode_e;

    // Hex nibble to active-low segment pattern
    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = SEG_A;
            4'hB:    code = SEG_B;
            4'hC:    code = SEG_C;
            4'hD:    code = SEG_D;
            4'hE:    code = SEG_E;
            4'hF:    code = SEG_F;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Ring slot (pos+offset) mod RING_LEN as {blank, nibble}; slot k<8 is nibble 7-k
    function automatic logic [4:0] ring_entry(input logic [31:0] word,
                                              input logic [3:0]  pos,
                                              input logic [1:0]  offset);
        logic [3:0] idx;
        logic [2:0] sel;
        logic [4:0] entry;
        idx = pos + {2'b00, offset};
        if (idx >= 4'(RING_LEN)) begin
            idx = idx - 4'(RING_LEN);
        end else begin
            idx = idx;
        end
        if (idx >= 4'd8) begin
            entry = {1'b1, 4'h0};
        end else begin
            sel   = 3'd7 - idx[2:0];
            entry = {1'b0, word[{sel, 2'b00} +: 4]};
        end
        return entry;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-segment decoder with a blank override.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_in,
    input  logic       blank_in,
    output logic [6:0] seg_out
);

    // Blank wins over the nibble value
    always_comb begin
        seg_out = SEG_BLANK;
        if (blank_in) begin
            seg_out = SEG_BLANK;
        end else begin
            seg_out = seg_code(nibble_in);
        end
    end

endmodule

// File: rtl/hex_scroll_driver.sv
// Four-digit active-low seven-segment driver for a 32-bit hex word.
// Shows the low or high half statically, blanks, or scrolls all eight
// digits through a four-digit window at STEP_CYCLES clocks per step.
// Optional blink feature: define SEG_BLINK_EN.
module hex_scroll_driver
    import seg_pkg::*;
#(
    parameter int STEP_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] value_in,
    input  logic [1:0]  mode_in,
    input  logic        blink_in,
    output logic [27:0] hex_out,
    output logic        step_tick
);

    localparam int                 PRESC_W   = $clog2(STEP_CYCLES);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(STEP_CYCLES - 1);
    localparam logic [3:0]         POS_LAST  = 4'(RING_LEN - 1);

    logic [31:0]        shadow_r;
    seg_mode_e          mode_q_r;
    logic [PRESC_W-1:0] presc_r;
    logic [3:0]         pos_r;
    logic               tc_r;
    logic               step_tick_r;
    logic [27:0]        hex_r;

    logic               restart_s;
    logic               tc_s;
    logic [3:0]         pos_nxt_s;
    logic [3:0][3:0]    nib_s;
    logic [3:0]         blank_s;
    logic [3:0][6:0]    seg_s;
    logic               force_off_s;

    // Any input change restarts the scroll; a restart masks the terminal count
    assign restart_s = (value_in != shadow_r) || (mode_in != mode_q_r);
    assign tc_s      = (presc_r == PRESC_MAX) && !restart_s;

    // Capture the displayed word and mode whenever they differ from the inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_r <= 32'h0000_0000;
            mode_q_r <= MODE_LO;
        end else begin
            if (value_in != shadow_r) shadow_r <= value_in;
            if (mode_in != mode_q_r)  mode_q_r <= seg_mode_e'(mode_in);
        end
    end

    // Step prescaler, free-running except for restarts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= '0;
        end else if (restart_s || (presc_r == PRESC_MAX)) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PRESC_W'(1);
        end
    end

    // Next scroll position: only moves in scroll mode, otherwise parked at 0
    always_comb begin
        pos_nxt_s = pos_r;
        if (restart_s || (mode_q_r != MODE_SCROLL)) begin
            pos_nxt_s = 4'd0;
        end else if (tc_s) begin
            pos_nxt_s = (pos_r == POS_LAST) ? 4'd0 : pos_r + 4'd1;
        end else begin
            pos_nxt_s = pos_r;
        end
    end

    // Scroll position register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_r <= 4'd0;
        end else begin
            pos_r <= pos_nxt_s;
        end
    end

    // Tick is delayed one edge so it lines up with the display showing the new pos
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tc_r        <= 1'b0;
            step_tick_r <= 1'b0;
        end else begin
            tc_r        <= tc_s;
            step_tick_r <= tc_r;
        end
    end

    // Pick the nibble and blank flag for each digit; index h is HEXh
    always_comb begin
        nib_s   = '0;
        blank_s = 4'b1111;
        case (mode_q_r)
            MODE_LO: begin
                for (int h = 0; h < 4; h++) begin
                    nib_s[h]   = shadow_r[h*4 +: 4];
                    blank_s[h] = 1'b0;
                end
            end
            MODE_HI: begin
                for (int h = 0; h < 4; h++) begin
                    nib_s[h]   = shadow_r[h*4+16 +: 4];
                    blank_s[h] = 1'b0;
                end
            end
            MODE_SCROLL: begin
                for (int h = 0; h < 4; h++) begin
                    {blank_s[h], nib_s[h]} = ring_entry(shadow_r, pos_r, 2'(3 - h));
                end
            end
            MODE_OFF: begin
                nib_s   = '0;
                blank_s = 4'b1111;
            end
            default: begin
                nib_s   = '0;
                blank_s = 4'b1111;
            end
        endcase
    end

    for (genvar h = 0; h < 4; h++) begin : g_dec
        seg_hex_decode u_dec (
            .nibble_in (nib_s[h]),
            .blank_in  (blank_s[h]),
            .seg_out   (seg_s[h])
        );
    end

`ifdef SEG_BLINK_EN
    logic blink_ph_r;

    // Blink phase flips on each step and restarts in the visible phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_ph_r <= 1'b0;
        end else if (restart_s) begin
            blink_ph_r <= 1'b0;
        end else if (tc_s) begin
            blink_ph_r <= ~blink_ph_r;
        end
    end

    assign force_off_s = blink_in & blink_ph_r;
`else
    // blink_in has no effect in this build
    assign force_off_s = blink_in & 1'b0;
`endif

    // Registered segment outputs, all off in reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_r <= 28'hFFF_FFFF;
        end else if (force_off_s) begin
            hex_r <= 28'hFFF_FFFF;
        end else begin
            hex_r <= seg_s;
        end
    end

    assign hex_out   = hex_r;
    assign step_tick = step_tick_r;

endmodule
